cand_slots: RTL and testbench
=============================

CAND_SLOTS -- requirements
Module: cand_slots

Interface
REQ-001 SHALL have parameter NSLOT, default 13, the number of candidate slots.
REQ-002 SHALL have parameter COST_W, default 8, the cost width in bits.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset; asynchronous, active-high.
REQ-005 SHALL have port ins_valid, input, 1 bit, an insert request.
REQ-006 SHALL have port ins_cost, input, COST_W bits, the cost to insert.
REQ-007 SHALL have port ins_ready, output, 1 bit, set when an insert can be accepted this cycle.
REQ-008 SHALL have port pop_req, input, 1 bit, a single-cycle request to remove an entry.
REQ-009 SHALL have port pop_cost, input, COST_W bits, the cost to remove (the winner from the min selector).
REQ-010 SHALL have port pop_hit, output, 1 bit, a registered one-cycle pulse: the pop removed an entry.
REQ-011 SHALL have port pop_miss, output, 1 bit, a registered one-cycle pulse: no entry matched the pop.
REQ-012 SHALL have port slot_en, output, NSLOT bits, the per-slot valid flags; they drive the min selector's pN_en inputs.
REQ-013 SHALL have port slot_val, output, NSLOT*COST_W bits, the flattened slot costs; slot i occupies bits [i*COST_W +: COST_W].
REQ-014 SHALL have port count, output, 4 bits, the number of valid slots.
REQ-015 SHALL have ports full and empty, output, 1 bit each: count==NSLOT and count==0.

Function
REQ-016 SHALL accept an insert when ins_valid&&ins_ready, where ins_ready = ~full (combinational).
REQ-017 SHALL write an accepted insert into the lowest-index invalid slot; slot_en and slot_val SHALL update at the next edge (1-cycle latency).
REQ-018 SHALL drive an invalid slot's slot_val to all-ones (COST_EMPTY) so it never wins a min compare.
REQ-019 SHALL, on pop_req, clear the lowest-index valid slot whose value equals pop_cost, then pulse pop_hit the next cycle.
REQ-020 SHALL, on pop_req with no matching slot, change no slot and pulse pop_miss the next cycle.
REQ-021 SHALL, on simultaneous accepted insert and pop, perform both in the same cycle.
REQ-022 SHALL choose the insert's free slot from the state before the pop, so a slot freed by a pop is not reused in that same cycle.
REQ-023 SHALL, on simultaneous insert and pop, keep count unchanged on a hit and increment it by 1 on a miss.
REQ-024 SHALL, when full and pop_req coincide, keep ins_ready low; the insert is not accepted.
REQ-025 SHALL, on pop_req while empty, pulse pop_miss.
REQ-026 SHALL never let count exceed NSLOT or go below 0.

Reset
REQ-027 SHALL, on rst high, immediately clear slot_en to all zeros, set every slot_val to COST_EMPTY, and set count=0, pop_hit=0 and pop_miss=0, with no clock required.
REQ-028 SHALL drop any insert or pop in flight when rst asserts; after rst deasserts, ins_ready=1 and empty=1.

Configuration
REQ-029 SHALL, with CAND_SLOTS_DEDUP_EN defined, acknowledge but not store an accepted insert whose cost equals any valid slot (count unchanged), comparing against state before a same-cycle pop.
REQ-030 SHALL, without CAND_SLOTS_DEDUP_EN, store duplicate costs in separate slots.

Structure
REQ-031 SHALL take NSLOT, COST_W and COST_EMPTY from shared package maze_pkg.
REQ-032 SHALL use one sub-module, cand_pri_enc (NSLOT-bit lowest-set-bit priority encoder returning index plus found flag), instantiated twice: once for the free-slot search and once for the pop-match search.

Verification
REQ-033 SHALL verify: after reset, insert 30,10,20 -> slot_en=13'b0000000000111, slot_val slots 0..2=30,10,20, others 8'hFF, count=3.
REQ-034 SHALL verify: with the slots above, pop_req pop_cost=10 -> pop_hit next cycle, slot 1 invalid and 8'hFF; then insert 5 -> lands in slot 1.
REQ-035 SHALL verify: insert 13 values 1..13 -> full=1, ins_ready=0; a 14th ins_valid is not accepted; pop_cost=7 plus ins 99 in the same cycle -> pop_hit, 99 rejected, count=12.
REQ-036 SHALL verify: with 4 valid slots, insert 50 and pop_cost=77 (absent) in the same cycle -> pop_miss, 50 stored, count=5.
REQ-037 SHALL verify: insert 40 twice -> count=2 without CAND_SLOTS_DEDUP_EN and count=1 with it.
REQ-038 SHALL verify: assert rst mid-insert with count=6 -> all slot_en=0 and count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared maze-router constants: candidate slot geometry and the empty-slot cost.
package maze_pkg;
    localparam int NSLOT  = 13;
    localparam int COST_W = 8;
    // All-ones so an empty slot never wins a min compare.
    localparam logic [COST_W-1:0] COST_EMPTY = {COST_W{1'b1}};
endpackage

// File: rtl/cand_pri_enc.sv
// Lowest-set-bit priority encoder: returns the index of the lowest set request bit plus a found flag.
module cand_pri_enc #(
    parameter int N     = 13,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scan upward and latch the first set bit.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && !found) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end else begin
                idx   = idx;
                found = found;
            end
        end
    end

endmodule

// File: rtl/cand_slots.sv
// Candidate slot store feeding the min selector: insert into the lowest free slot, pop by cost match.
// Optional macro CAND_SLOTS_DEDUP_EN: drop inserts whose cost is already held in a valid slot.
module cand_slots #(
    parameter int NSLOT  = maze_pkg::NSLOT,
    parameter int COST_W = maze_pkg::COST_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ins_valid,
    input  logic [COST_W-1:0]       ins_cost,
    output logic                    ins_ready,
    input  logic                    pop_req,
    input  logic [COST_W-1:0]       pop_cost,
    output logic                    pop_hit,
    output logic                    pop_miss,
    output logic [NSLOT-1:0]        slot_en,
    output logic [NSLOT*COST_W-1:0] slot_val,
    output logic [3:0]              count,
    output logic                    full,
    output logic                    empty
);

    localparam int IDX_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam logic [COST_W-1:0] EMPTY_C = COST_W'(maze_pkg::COST_EMPTY);

    logic [NSLOT-1:0]        slot_en_r, en_nx_s, match_s;
    logic [NSLOT*COST_W-1:0] slot_val_r, val_nx_s;
    logic [3:0]              count_r, count_nx_s;
    logic                    pop_hit_r, pop_miss_r;
    logic [IDX_W-1:0]        free_idx_s, match_idx_s;
    logic                    free_found_s, match_found_s;
    logic                    ins_acc_s, ins_store_s, pop_hit_s;

    assign full      = (count_r == 4'(NSLOT));
    assign empty     = (count_r == 4'd0);
    assign ins_ready = ~full;
    assign ins_acc_s = ins_valid && ins_ready;
    assign pop_hit_s = pop_req && match_found_s;

    // Per-slot pop match; only valid slots may match.
    always_comb begin
        match_s = '0;
        for (int i = 0; i < NSLOT; i++) begin
            match_s[i] = slot_en_r[i] && (slot_val_r[i*COST_W +: COST_W] == pop_cost);
        end
    end

    cand_pri_enc #(.N(NSLOT), .IDX_W(IDX_W)) u_free_enc (
        .req   (~slot_en_r),
        .idx   (free_idx_s),
        .found (free_found_s)
    );

    cand_pri_enc #(.N(NSLOT), .IDX_W(IDX_W)) u_match_enc (
        .req   (match_s),
        .idx   (match_idx_s),
        .found (match_found_s)
    );

`ifdef CAND_SLOTS_DEDUP_EN
    logic dup_s;

    // Duplicate detection against the pre-pop contents.
    always_comb begin
        dup_s = 1'b0;
        for (int i = 0; i < NSLOT; i++) begin
            if (slot_en_r[i] && (slot_val_r[i*COST_W +: COST_W] == ins_cost)) begin
                dup_s = 1'b1;
            end else begin
                dup_s = dup_s;
            end
        end
    end

    assign ins_store_s = ins_acc_s && !dup_s;
`else
    assign ins_store_s = ins_acc_s;
`endif

    // Next slot contents; the free slot comes from pre-pop state so it can never be the popped one.
    always_comb begin
        en_nx_s  = slot_en_r;
        val_nx_s = slot_val_r;
        if (pop_hit_s) begin
            en_nx_s[match_idx_s] = 1'b0;
            val_nx_s[int'(match_idx_s)*COST_W +: COST_W] = EMPTY_C;
        end else begin
            en_nx_s = en_nx_s;
        end
        if (ins_store_s && free_found_s) begin
            en_nx_s[free_idx_s] = 1'b1;
            val_nx_s[int'(free_idx_s)*COST_W +: COST_W] = ins_cost;
        end else begin
            val_nx_s = val_nx_s;
        end
    end

    // Occupancy tracking.
    always_comb begin
        case ({ins_store_s, pop_hit_s})
            2'b10:   count_nx_s = count_r + 4'd1;
            2'b01:   count_nx_s = count_r - 4'd1;
            default: count_nx_s = count_r;
        endcase
    end

    // State and registered pop result pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_en_r  <= '0;
            slot_val_r <= {NSLOT{EMPTY_C}};
            count_r    <= 4'd0;
            pop_hit_r  <= 1'b0;
            pop_miss_r <= 1'b0;
        end else begin
            slot_en_r  <= en_nx_s;
            slot_val_r <= val_nx_s;
            count_r    <= count_nx_s;
            pop_hit_r  <= pop_hit_s;
            pop_miss_r <= pop_req && !match_found_s;
        end
    end

    assign slot_en  = slot_en_r;
    assign slot_val = slot_val_r;
    assign count    = count_r;
    assign pop_hit  = pop_hit_r;
    assign pop_miss = pop_miss_r;

endmodule

// File: tb/tb_cand_slots.sv
// Directed bench for cand_slots: slot-list model checked every cycle plus hand-computed expectations.
module tb_cand_slots;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ins_valid = 1'b0;
    logic [7:0]   ins_cost = 8'd0;
    logic         ins_ready;
    logic         pop_req = 1'b0;
    logic [7:0]   pop_cost = 8'd0;
    logic         pop_hit, pop_miss;
    logic [12:0]  slot_en;
    logic [103:0] slot_val;
    logic [3:0]   count;
    logic         full, empty;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    // Model: which slots hold a cost, and what cost.
    bit        m_en  [13];
    int        m_val [13];
    int        m_cnt  = 0;
    bit        m_hit  = 1'b0;
    bit        m_miss = 1'b0;

    always #5 clk = ~clk;

    cand_slots dut (
        .clk(clk), .rst(rst),
        .ins_valid(ins_valid), .ins_cost(ins_cost), .ins_ready(ins_ready),
        .pop_req(pop_req), .pop_cost(pop_cost), .pop_hit(pop_hit), .pop_miss(pop_miss),
        .slot_en(slot_en), .slot_val(slot_val), .count(count), .full(full), .empty(empty)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [12:0] exp_en();
        logic [12:0] v;
        for (int i = 0; i < 13; i++) v[i] = m_en[i];
        return v;
    endfunction

    function automatic logic [103:0] exp_val();
        logic [103:0] v;
        for (int i = 0; i < 13; i++) v[i*8 +: 8] = m_en[i] ? 8'(m_val[i]) : 8'hFF;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 13; i++) begin
            m_en[i]  = 1'b0;
            m_val[i] = 0;
        end
        m_cnt  = 0;
        m_hit  = 1'b0;
        m_miss = 1'b0;
    endtask

    // One clock of stimulus; the model is advanced from the rules, then exposed after the edge.
    task automatic step(input logic iv, input logic [7:0] ic, input logic pr, input logic [7:0] pc);
        bit n_en [13];
        int n_val [13];
        int hit_i, free_i;
        bit acc, dup;
        ins_valid = iv; ins_cost = ic; pop_req = pr; pop_cost = pc;
        acc = iv && (m_cnt < 13);
        hit_i = -1; free_i = -1; dup = 1'b0;
        for (int i = 0; i < 13; i++) begin
            if (hit_i < 0 && pr && m_en[i] && m_val[i] == int'(pc)) hit_i = i;
            if (free_i < 0 && !m_en[i]) free_i = i;
            if (m_en[i] && m_val[i] == int'(ic)) dup = 1'b1;
        end
`ifndef CAND_SLOTS_DEDUP_EN
        dup = 1'b0;
`endif
        n_en = m_en; n_val = m_val;
        if (hit_i >= 0) n_en[hit_i] = 1'b0;
        if (acc && !dup && free_i >= 0) begin
            n_en[free_i]  = 1'b1;
            n_val[free_i] = int'(ic);
        end
        @(posedge clk);
        #1;
        m_en = n_en; m_val = n_val;
        m_cnt = 0;
        for (int i = 0; i < 13; i++) m_cnt += int'(m_en[i]);
        m_hit  = pr && (hit_i >= 0);
        m_miss = pr && (hit_i < 0);
        ins_valid = 1'b0; pop_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ins_valid = 1'b0; pop_req = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("post_rst_ready", 128'(ins_ready), 128'(1'b1));
        chk("post_rst_empty", 128'(empty), 128'(1'b1));
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("slot_en", 128'(slot_en), 128'(exp_en()));
            chk("slot_val", 128'(slot_val), 128'(exp_val()));
            chk("count", 128'(count), 128'(m_cnt));
            chk("full", 128'(full), 128'(m_cnt == 13));
            chk("empty", 128'(empty), 128'(m_cnt == 0));
            chk("ins_ready", 128'(ins_ready), 128'(m_cnt != 13));
            chk("pop_hit", 128'(pop_hit), 128'(m_hit));
            chk("pop_miss", 128'(pop_miss), 128'(m_miss));
        end
    end

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_slot_en", 128'(slot_en), 128'(13'd0));
        chk("rst_slot_val", 128'(slot_val), {24'd0, {13{8'hFF}}});
        chk("rst_count", 128'(count), 128'(4'd0));
        rst = 1'b0;
        chk_on = 1'b1;

        // Three inserts land in slots 0..2.
        step(1'b1, 8'd30, 1'b0, 8'd0);
        step(1'b1, 8'd10, 1'b0, 8'd0);
        step(1'b1, 8'd20, 1'b0, 8'd0);
        chk("ins3_en", 128'(slot_en), 128'(13'b0000000000111));
        chk("ins3_val", 128'(slot_val), {24'd0, {10{8'hFF}}, 8'd20, 8'd10, 8'd30});
        chk("ins3_count", 128'(count), 128'(4'd3));

        // Pop 10 frees slot 1; next insert reuses it.
        step(1'b0, 8'd0, 1'b1, 8'd10);
        chk("pop10_hit", 128'(pop_hit), 128'(1'b1));
        chk("pop10_en1", 128'(slot_en[1]), 128'(1'b0));
        chk("pop10_val1", 128'(slot_val[15:8]), 128'(8'hFF));
        step(1'b1, 8'd5, 1'b0, 8'd0);
        chk("ins5_slot1", 128'(slot_val[15:8]), 128'(8'd5));

        // Same-cycle pop of slot 0 and insert: the insert must go to slot 3, not slot 0.
        step(1'b1, 8'd60, 1'b1, 8'd30);
        chk("nofreeuse_en", 128'(slot_en), 128'(13'b0000000001110));
        chk("nofreeuse_val3", 128'(slot_val[31:24]), 128'(8'd60));
        chk("nofreeuse_cnt", 128'(count), 128'(4'd3));

        // Fill to 13, reject a 14th, then pop 7 with a rejected insert.
        do_reset();
        for (int v = 1; v <= 13; v++) step(1'b1, 8'(v), 1'b0, 8'd0);
        chk("fill_full", 128'(full), 128'(1'b1));
        chk("fill_ready", 128'(ins_ready), 128'(1'b0));
        step(1'b1, 8'd14, 1'b0, 8'd0);
        chk("ins14_count", 128'(count), 128'(4'd13));
        step(1'b1, 8'd99, 1'b1, 8'd7);
        chk("fullpop_hit", 128'(pop_hit), 128'(1'b1));
        chk("fullpop_count", 128'(count), 128'(4'd12));
        chk("fullpop_slot6", 128'(slot_val[55:48]), 128'(8'hFF));

        // Absent pop plus insert: miss and count grows.
        do_reset();
        step(1'b0, 8'd0, 1'b1, 8'd3);
        chk("emptypop_miss", 128'(pop_miss), 128'(1'b1));
        for (int v = 1; v <= 4; v++) step(1'b1, 8'(v * 11), 1'b0, 8'd0);
        step(1'b1, 8'd50, 1'b1, 8'd77);
        chk("miss_pulse", 128'(pop_miss), 128'(1'b1));
        chk("miss_count", 128'(count), 128'(4'd5));
        chk("miss_slot4", 128'(slot_val[39:32]), 128'(8'd50));

        // Duplicate insert.
        do_reset();
        step(1'b1, 8'd40, 1'b0, 8'd0);
        step(1'b1, 8'd40, 1'b0, 8'd0);
`ifdef CAND_SLOTS_DEDUP_EN
        chk("dup_count", 128'(count), 128'(4'd1));
`else
        chk("dup_count", 128'(count), 128'(4'd2));
`endif

        // Asynchronous reset mid-insert with six entries.
        do_reset();
        for (int v = 1; v <= 6; v++) step(1'b1, 8'(v + 100), 1'b0, 8'd0);
        chk("pre_arst_count", 128'(count), 128'(4'd6));
        ins_valid = 1'b1; ins_cost = 8'd123;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_en", 128'(slot_en), 128'(13'd0));
        chk("arst_count", 128'(count), 128'(4'd0));
        chk("arst_val", 128'(slot_val), {24'd0, {13{8'hFF}}});
        @(posedge clk);
        #1;
        ins_valid = 1'b0;
        rst = 1'b0;
        chk("arst_ready", 128'(ins_ready), 128'(1'b1));
        chk("arst_empty", 128'(empty), 128'(1'b1));
        step(1'b0, 8'd0, 1'b0, 8'd0);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
